// File: rtl/frame_feeder_if.sv
// Producer-side byte stream into frame_feeder: valid/ready handshake.
// master = producer, slave = feeder.
interface frame_feeder_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/frame_feeder.sv
// Buffers a DEPTH-byte frame from the producer, streams it once to the averaging
// core behind a start pulse, then holds off the producer until the core reports done.
module frame_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  frame_feeder_if.slave    prod,
  output logic             start,
  output logic [WIDTH-1:0] data,
  input  logic             done,
  output logic             busy,
  output logic [7:0]       frame_count
);
  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [7:0]       frame_count_reg;
  logic [WIDTH-1:0] buf_reg [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic             accept;

  assign accept = prod.in_valid && prod.in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = accept && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        buf_reg[i] <= prod.in_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:      if (accept && wr_ptr_reg == LAST) state_next = STREAM;
      STREAM:    if (rd_ptr_reg == LAST) state_next = WAIT_DONE;
      WAIT_DONE: if (done) state_next = FILL;
      default:   state_next = FILL;
    endcase
  end

  // DEPTH is a power of two, so the natural wrap of each pointer clears it
  // on the same edge that leaves FILL / STREAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      frame_count_reg <= '0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (state_reg == STREAM) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (state_reg == WAIT_DONE && done) begin
        frame_count_reg <= frame_count_reg + 8'd1;
      end
    end
  end

  always_comb begin
    prod.in_ready = 1'b0;
    busy          = 1'b0;
    start         = 1'b0;
    data          = '0;
    case (state_reg)
      FILL:      prod.in_ready = !reset;
      STREAM: begin
        busy  = 1'b1;
        start = (rd_ptr_reg == '0);
        data  = buf_reg[rd_ptr_reg];
      end
      WAIT_DONE: busy = 1'b1;
      default:   ;
    endcase
  end

  assign frame_count = frame_count_reg;
endmodule
